cpu_branch_target_buffer: RTL and testbench
===========================================

# cpu_branch_target_buffer

Set-associative branch target buffer with per-entry saturating direction counters, tree pseudo-LRU replacement, and optional global-history index hashing. It sits in the fetch stage. Each cycle it gives a combinational hit/taken/target prediction for the fetch address. Resolved branches from execute train it one update per cycle. It is the parametrised successor of the direction-only predictor and adds stored targets, selectable associativity, history hashing and flush.

## Interface
Parameters:
- XLEN, 32, address/target width
- CTR_WIDTH, 2, saturating counter width (>=2)
- BYTE_OFFSET, 2, low address bits ignored
- SET_WIDTH, 4, log2(sets)
- WAY_WIDTH, 1, log2(ways), >=1; ways N = 2**WAY_WIDTH
- GHR_WIDTH, 0, global history length; 0 disables hashing; must be <= SET_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  invalidate all entries this cycle
- addr  in  XLEN  lookup (fetch) address
- hit  out  1  lookup matched a valid entry
- taken  out  1  predicted taken
- target  out  XLEN  predicted target
- hist  out  max(GHR_WIDTH,1)  current GHR; 0 when GHR_WIDTH=0
- update  in  1  train with a resolved branch this cycle
- update_addr  in  XLEN  resolved branch address
- update_taken  in  1  resolved direction
- update_target  in  XLEN  resolved target
- update_hist  in  max(GHR_WIDTH,1)  the `hist` value sampled when this branch was predicted

## Operation
- Field split of an address:
  - Set bits: [BYTE_OFFSET+SET_WIDTH-1:BYTE_OFFSET].
  - Tag: the remaining upper bits, TAG_WIDTH = XLEN-SET_WIDTH-BYTE_OFFSET.
- Index:
  - Lookup: set = set bits XOR zero-extended GHR.
  - Update: set = set bits XOR zero-extended update_hist.
  - With GHR_WIDTH=0 the index is the set bits alone.
- Per entry: valid, tag, target[XLEN], counter[CTR_WIDTH]. Per set: N-1 tree-PLRU bits.
- Lookup (combinational):
  - hit = some way in the set is valid and its tag matches.
  - taken = hit & counter MSB.
  - target = the stored target on a hit, 0 on a miss.
  - Lookup does not touch PLRU state.
- Update hit (matching way in the update set):
  - Taken: counter +1, saturating at all-ones; stored target <= update_target.
  - Not taken: counter -1, saturating at 0; target unchanged.
  - Touch the way in PLRU.
- Update miss, update_taken=1 (allocate):
  - Victim is the lowest-index invalid way; if all ways are valid, the PLRU victim.
  - Write valid=1, tag, target=update_target, counter=weakly taken (1 followed by zeros).
  - Touch the victim in PLRU.
- Update miss, update_taken=0: no array change.
- Tree PLRU:
  - A node bit of 0 points the victim search to the lower-index half, 1 to the upper half.
  - A touch of way w sets every node on w's path to point away from w.
- GHR: on every update, GHR <= {GHR[GHR_WIDTH-2:0], update_taken}, including when flush is asserted.
- Allocation only on miss, so no set ever holds duplicate tags.

## Timing
- Lookup latency 0 cycles. An update is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update contents.
- Reset (async, any time, including mid-update):
  - Clears all valid bits, PLRU bits and GHR immediately.
  - Outputs go to hit=0, taken=0, target=0, hist=0.
  - Counters, tags and targets are not reset.
- flush (synchronous):
  - Clears all valid and PLRU bits at the edge.
  - An update in the same cycle is dropped for the arrays; the GHR still shifts.
- Counter arithmetic is CTR_WIDTH-bit with explicit saturation; it never wraps.
- Update set/tag are computed from the update inputs only, independent of the current lookup.

## Test plan
- Cold start and allocate (defaults):
  - After reset, lookup 0x100 gives hit=0, taken=0, target=0.
  - Update 0x100, taken, target 0x200 → next cycle hit=1, taken=1, target=0x200, counter 2'b10.
- Saturation:
  - On entry 0x100, three not-taken updates take the counter 10→01→00→00, with taken=0 and hit=1 throughout.
  - Then four taken updates take it 01→10→11→11.
  - After the first not-taken update the target stays 0x200.
- No allocation on not-taken miss: update 0x300 not-taken → lookup 0x300 hit=0 on every later cycle.
- PLRU eviction (N=2, set 0, stride 0x40):
  - Allocate 0x000, then 0x040, then a taken update to 0x000 (touch), then allocate 0x080.
  - Then lookup 0x040 gives hit=0; 0x000 and 0x080 give hit=1.
- Flush and reset:
  - Flush in the same cycle as a taken update to 0x500 → next cycle 0x100 and 0x500 both miss, and hist has shifted.
  - Assert rst mid-cycle → hit=0 and hist=0 before the next edge.
- Hashing (GHR_WIDTH=2):
  - Two taken updates to 0x700 bring hist to 2'b11.
  - Then update 0x000, taken, update_hist=2'b01 allocates in set 1.
  - Lookup 0x000 misses while hist=2'b11. After updates not-taken then taken (hist 2'b01) it hits.

Source files
------------

// File: rtl/cpu_branch_target_buffer_if.sv
// Fetch/execute-side bundle of the branch target buffer: lookup, prediction and training signals.
interface cpu_branch_target_buffer_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned GHR_WIDTH = 0
);
    localparam int unsigned HW = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;

    logic            flush;
    logic [XLEN-1:0] addr;
    logic            hit;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [HW-1:0]   hist;
    logic            update;
    logic [XLEN-1:0] update_addr;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic [HW-1:0]   update_hist;

    modport master (
        output flush, addr, update, update_addr, update_taken, update_target, update_hist,
        input  hit, taken, target, hist
    );

    modport slave (
        input  flush, addr, update, update_addr, update_taken, update_target, update_hist,
        output hit, taken, target, hist
    );
endinterface

// File: rtl/cpu_branch_target_buffer.sv
// Set-associative BTB: combinational hit/taken/target lookup, per-entry saturating counters,
// tree pseudo-LRU replacement and optional global-history index hashing.
module cpu_branch_target_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CTR_WIDTH   = 2,
    parameter int unsigned BYTE_OFFSET = 2,
    parameter int unsigned SET_WIDTH   = 4,
    parameter int unsigned WAY_WIDTH   = 1,
    parameter int unsigned GHR_WIDTH   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    cpu_branch_target_buffer_if.slave  bus
);
    localparam int unsigned SETS      = 1 << SET_WIDTH;
    localparam int unsigned WAYS      = 1 << WAY_WIDTH;
    localparam int unsigned TAG_LSB   = BYTE_OFFSET + SET_WIDTH;
    localparam int unsigned TAG_WIDTH = XLEN - TAG_LSB;
    localparam int unsigned HW        = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
    localparam bit          HASH      = (GHR_WIDTH != 0);
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T = {1'b1, {(CTR_WIDTH-1){1'b0}}};

    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-2:0]      plru_q  [SETS];
    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [XLEN-1:0]      tgt_q   [SETS][WAYS];
    logic [CTR_WIDTH-1:0] ctr_q   [SETS][WAYS];
    logic [HW-1:0]        ghr_q, ghr_d;

    logic [SET_WIDTH-1:0] lk_set, up_set;
    logic [TAG_WIDTH-1:0] lk_tag, up_tag;
    logic                 lk_hit, up_hit, inv_any, wr_en;
    logic [WAY_WIDTH-1:0] lk_way, up_way, inv_way, plru_way, wr_way;
    logic [WAY_WIDTH-1:0] vnode, tnode;
    logic                 vbit, tbit;
    logic [WAYS-2:0]      plru_d;
    logic [CTR_WIDTH-1:0] ctr_cur, ctr_d;

    assign lk_set = bus.addr[TAG_LSB-1:BYTE_OFFSET] ^ (HASH ? SET_WIDTH'(ghr_q) : '0);
    assign lk_tag = bus.addr[XLEN-1:TAG_LSB];
    assign up_set = bus.update_addr[TAG_LSB-1:BYTE_OFFSET] ^ (HASH ? SET_WIDTH'(bus.update_hist) : '0);
    assign up_tag = bus.update_addr[XLEN-1:TAG_LSB];

    // Lookup path: tags are unique per set, so at most one way matches
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_WIDTH'(w);
            end
        end
    end

    assign bus.hit    = lk_hit;
    assign bus.taken  = lk_hit & ctr_q[lk_set][lk_way][CTR_WIDTH-1];
    assign bus.target = lk_hit ? tgt_q[lk_set][lk_way] : '0;
    assign bus.hist   = ghr_q;

    // Training path: match, victim choice, PLRU touch and counter step
    always_comb begin
        up_hit   = 1'b0;
        up_way   = '0;
        inv_any  = 1'b0;
        inv_way  = '0;
        plru_way = '0;
        vnode    = '0;
        vbit     = 1'b0;
        tnode    = '0;
        tbit     = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[up_set][w] && (tag_q[up_set][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_WIDTH'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[up_set][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_WIDTH'(w);
            end
        end
        // Walk the tree from the root; node n has children 2n+1 (lower) and 2n+2 (upper)
        for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
            vbit     = plru_q[up_set][vnode];
            plru_way = WAY_WIDTH'({plru_way, vbit});
            vnode    = WAY_WIDTH'({vnode, 1'b1}) + WAY_WIDTH'(vbit);
        end
        wr_way = up_hit ? up_way : (inv_any ? inv_way : plru_way);

        plru_d = plru_q[up_set];
        for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
            tbit          = wr_way[WAY_WIDTH-1-l];
            plru_d[tnode] = ~tbit;
            tnode         = WAY_WIDTH'({tnode, 1'b1}) + WAY_WIDTH'(tbit);
        end

        ctr_cur = ctr_q[up_set][up_way];
        if (!up_hit)
            ctr_d = CTR_WEAK_T;
        else if (bus.update_taken)
            ctr_d = (ctr_cur == '1) ? ctr_cur : ctr_cur + CTR_WIDTH'(1);
        else
            ctr_d = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_WIDTH'(1);

        wr_en = bus.update & ~bus.flush & (up_hit | bus.update_taken);
        ghr_d = HASH ? HW'({ghr_q, bus.update_taken}) : '0;
    end

    // Valid, PLRU and history state; flush drops the array write but history still shifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            ghr_q <= '0;
        end else begin
            if (bus.flush) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end
            end else if (wr_en) begin
                valid_q[up_set][wr_way] <= 1'b1;
                plru_q[up_set]          <= plru_d;
            end
            if (bus.update) ghr_q <= ghr_d;
        end
    end

    // Payload arrays carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_set][wr_way] <= up_tag;
            ctr_q[up_set][wr_way] <= ctr_d;
            if (bus.update_taken) tgt_q[up_set][wr_way] <= bus.update_target;
        end
    end

    logic unused_sink;
    assign unused_sink = ^{bus.addr, bus.update_addr, bus.update_hist};
endmodule

// File: tb/tb_cpu_branch_target_buffer.sv
// Directed bench for the BTB: a default instance and a GHR_WIDTH=2 hashing instance share clock and reset.
module tb_cpu_branch_target_buffer;
    logic clk = 1'b0;
    logic rst;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    cpu_branch_target_buffer_if #(.XLEN(32), .GHR_WIDTH(0)) b0 ();
    cpu_branch_target_buffer_if #(.XLEN(32), .GHR_WIDTH(2)) b1 ();

    cpu_branch_target_buffer dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    cpu_branch_target_buffer #(.GHR_WIDTH(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd0(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic fl);
        b0.update = 1'b1; b0.update_addr = a; b0.update_taken = t;
        b0.update_target = tg; b0.update_hist = '0; b0.flush = fl;
        tick();
        b0.update = 1'b0; b0.flush = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] a, input logic t, input logic [31:0] tg,
                        input logic [1:0] h, input logic fl);
        b1.update = 1'b1; b1.update_addr = a; b1.update_taken = t;
        b1.update_target = tg; b1.update_hist = h; b1.flush = fl;
        tick();
        b1.update = 1'b0; b1.flush = 1'b0;
    endtask

    task automatic look0(input string tag, input logic [31:0] a, input logic h, input logic t,
                         input logic [31:0] tg);
        b0.addr = a;
        #1;
        check_eq({tag, ".hit"}, 64'(b0.hit), 64'(h));
        check_eq({tag, ".taken"}, 64'(b0.taken), 64'(t));
        check_eq({tag, ".target"}, 64'(b0.target), 64'(tg));
    endtask

    task automatic look1(input string tag, input logic [31:0] a, input logic h, input logic [31:0] tg);
        b1.addr = a;
        #1;
        check_eq({tag, ".hit"}, 64'(b1.hit), 64'(h));
        check_eq({tag, ".target"}, 64'(b1.target), 64'(tg));
    endtask

    initial begin
        rst = 1'b1;
        b0.flush = 0; b0.addr = '0; b0.update = 0; b0.update_addr = '0;
        b0.update_taken = 0; b0.update_target = '0; b0.update_hist = '0;
        b1.flush = 0; b1.addr = '0; b1.update = 0; b1.update_addr = '0;
        b1.update_taken = 0; b1.update_target = '0; b1.update_hist = '0;
        tick();

        // Reset state
        look0("rst", 32'h100, 0, 0, 32'h0);
        check_eq("rst.hist0", 64'(b0.hist), 64'h0);
        check_eq("rst.hist1", 64'(b1.hist), 64'h0);
        rst = 1'b0;
        tick();

        // Cold miss then allocate weakly taken
        look0("cold", 32'h100, 0, 0, 32'h0);
        upd0(32'h100, 1, 32'h200, 0);
        look0("alloc", 32'h100, 1, 1, 32'h200);

        // Down to 00 and saturate; target untouched by not-taken
        upd0(32'h100, 0, 32'h999, 0); look0("nt1", 32'h100, 1, 0, 32'h200);
        upd0(32'h100, 0, 32'h999, 0); look0("nt2", 32'h100, 1, 0, 32'h200);
        upd0(32'h100, 0, 32'h999, 0); look0("nt3", 32'h100, 1, 0, 32'h200);
        // Up to 11 and saturate, taken hits rewrite the target
        upd0(32'h100, 1, 32'h204, 0); look0("t1", 32'h100, 1, 0, 32'h204);
        upd0(32'h100, 1, 32'h204, 0); look0("t2", 32'h100, 1, 1, 32'h204);
        upd0(32'h100, 1, 32'h204, 0); look0("t3", 32'h100, 1, 1, 32'h204);
        upd0(32'h100, 1, 32'h204, 0); look0("t4", 32'h100, 1, 1, 32'h204);
        upd0(32'h100, 0, 32'h999, 0); look0("d1", 32'h100, 1, 1, 32'h204);
        upd0(32'h100, 0, 32'h999, 0); look0("d2", 32'h100, 1, 0, 32'h204);

        // Not-taken miss allocates nothing
        upd0(32'h300, 0, 32'h333, 0);
        look0("ntmiss.a", 32'h300, 0, 0, 32'h0);
        tick();
        look0("ntmiss.b", 32'h300, 0, 0, 32'h0);

        // Flush with a same-cycle taken update
        upd0(32'h500, 1, 32'h555, 1);
        look0("flush.a", 32'h100, 0, 0, 32'h0);
        look0("flush.b", 32'h500, 0, 0, 32'h0);
        check_eq("flush.hist0", 64'(b0.hist), 64'h0);

        // PLRU: 0x040 is least recently used when 0x080 arrives
        upd0(32'h000, 1, 32'h010, 0);
        upd0(32'h040, 1, 32'h050, 0);
        upd0(32'h000, 1, 32'h010, 0);
        upd0(32'h080, 1, 32'h090, 0);
        look0("plru.evict", 32'h040, 0, 0, 32'h0);
        look0("plru.keep", 32'h000, 1, 1, 32'h010);
        look0("plru.new", 32'h080, 1, 1, 32'h090);

        // History hashing on the second instance
        tick();
        check_eq("ghr.0", 64'(b1.hist), 64'h0);
        upd1(32'h700, 1, 32'h777, 2'b00, 0);
        check_eq("ghr.1", 64'(b1.hist), 64'h1);
        upd1(32'h700, 1, 32'h777, 2'b01, 0);
        check_eq("ghr.2", 64'(b1.hist), 64'h3);
        upd1(32'h000, 1, 32'h0A0, 2'b01, 0);
        check_eq("ghr.3", 64'(b1.hist), 64'h3);
        look1("hash.miss", 32'h000, 0, 32'h0);
        upd1(32'h900, 0, 32'h0, 2'b11, 0);
        check_eq("ghr.4", 64'(b1.hist), 64'h2);
        upd1(32'h900, 1, 32'h990, 2'b10, 0);
        check_eq("ghr.5", 64'(b1.hist), 64'h1);
        look1("hash.hit", 32'h000, 1, 32'h0A0);

        // Flush drops the array write but the history still shifts
        upd1(32'h500, 1, 32'h555, 2'b01, 1);
        check_eq("flush1.hist", 64'(b1.hist), 64'h3);
        upd1(32'h900, 0, 32'h0, 2'b11, 0);
        upd1(32'hA00, 1, 32'hAAA, 2'b10, 0);
        check_eq("flush1.hist2", 64'(b1.hist), 64'h1);
        look1("flush1.a", 32'h000, 0, 32'h0);
        look1("flush1.b", 32'h500, 0, 32'h0);

        // Asynchronous reset between edges
        b0.addr = 32'h000;
        #1;
        check_eq("arst.pre", 64'(b0.hit), 64'h1);
        rst = 1'b1;
        #1;
        check_eq("arst.hit", 64'(b0.hit), 64'h0);
        check_eq("arst.taken", 64'(b0.taken), 64'h0);
        check_eq("arst.target", 64'(b0.target), 64'h0);
        check_eq("arst.hist", 64'(b1.hist), 64'h0);
        #2;
        rst = 1'b0;
        tick();
        look0("arst.post", 32'h000, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
